fifo_read: RTL and testbench

// - Read-side drain engine for the dual-clock 8-bit test FIFO; counterpart of the write-side burst filler.
// - Waits for the FIFO to report full, then reads until empty, streaming words out.
// - Checks every burst is the sequence 0,1,2,... (mod 2^DATA_W); flags and counts mismatches.
// - Sits in the read clock domain, directly on the FIFO rd* port pins.

---
 rtl/fifo_test_pkg.sv | 14 +
 rtl/fifo_seq_check.sv | 55 +++++
 rtl/fifo_read.sv | 128 ++++++++++++
 tb/tb_fifo_read.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_test_pkg.sv
// Shared definitions for the dual-clock test FIFO read and write engines.
package fifo_test_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned SEQ_START  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_seq_check.sv
// Burst sequence checker: tracks the expected word, flags mismatches and
// keeps a saturating error count.
module fifo_seq_check
    import fifo_test_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              seq_err_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam logic [DATA_W-1:0] START = DATA_W'(SEQ_START);

    logic [DATA_W-1:0] exp_q, exp_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Expected value resyncs to the sampled word so a dropped word costs one error
    always_comb begin
        exp_d = exp_q;
        err_d = 1'b0;
        cnt_d = cnt_q;
        if (clr_i) begin
            exp_d = START;
        end else if (vld_i) begin
            err_d = (data_i != exp_q);
            exp_d = data_i + DATA_W'(1);
            if (err_d && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= START;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign seq_err_o = err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: rtl/fifo_read.sv
// Read-side drain engine: waits for FIFO full, reads until empty, streams
// the words out and checks each burst counts up from zero.
module fifo_read
    import fifo_test_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter bit          SHOWAHEAD = 1'b0,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdfull,
    input  logic              rdempty,
    input  logic [DATA_W-1:0] q,
    output logic              rdreq,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              seq_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              burst_done,
    output logic [CNT_W-1:0]  burst_len
);

    state_e            state_q, state_d;
    logic              drain_wait_q, drain_wait_d;
    logic              drain_last_c;
    logic              start_c;
    logic              done_c;
    logic              sample_c;
    logic              rdreq_q;
    logic              vld_q;
    logic              bdone_q;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  blen_q, blen_d;

    // Non-look-ahead FIFOs still owe the last word one clock after the final read
    assign drain_last_c = SHOWAHEAD || drain_wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            drain_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_wait_q <= drain_wait_d;
        end
    end

    // Empty wins over full, so a simultaneous full/empty never starts a burst
    always_comb begin
        state_d      = state_q;
        drain_wait_d = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (rdfull && !rdempty) state_d = ST_READ;
            ST_READ:  if (rdempty) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_last_c) state_d = ST_IDLE;
                else              drain_wait_d = 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdreq   = 1'b0;
        start_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE:  start_c = rdfull && !rdempty;
            ST_READ:  rdreq   = !rdempty;
            ST_DRAIN: done_c  = drain_last_c;
            default:  ;
        endcase
    end

    assign sample_c = SHOWAHEAD ? rdreq : rdreq_q;

    always_comb begin
        wcnt_d = wcnt_q;
        blen_d = blen_q;
        dout_d = dout_q;
        if (start_c) begin
            wcnt_d = '0;
        end else if (rdreq && (wcnt_q != '1)) begin
            wcnt_d = wcnt_q + CNT_W'(1);
        end
        if (sample_c) dout_d = q;
        if (done_c)   blen_d = wcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdreq_q <= 1'b0;
            vld_q   <= 1'b0;
            bdone_q <= 1'b0;
            dout_q  <= '0;
            wcnt_q  <= '0;
            blen_q  <= '0;
        end else begin
            rdreq_q <= rdreq;
            vld_q   <= sample_c;
            bdone_q <= done_c;
            dout_q  <= dout_d;
            wcnt_q  <= wcnt_d;
            blen_q  <= blen_d;
        end
    end

    fifo_seq_check #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_seq_check (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (start_c),
        .vld_i     (sample_c),
        .data_i    (q),
        .seq_err_o (seq_err),
        .err_cnt_o (err_cnt)
    );

    assign dout       = dout_q;
    assign dout_vld   = vld_q;
    assign burst_done = bdone_q;
    assign burst_len  = blen_q;

endmodule

// File: tb/tb_fifo_read.sv
// Bench for fifo_read: three instances (normal, look-ahead, narrow counters)
// each fed by a queue-based FIFO model, checked burst by burst.
module tb_fifo_read;

    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]      full, empty;
    logic [N-1:0][7:0] qd;
    wire  [N-1:0]      rdreq, vld, serr, bdone;
    wire  [N-1:0][7:0] dout;
    wire  [15:0]       ecnt0, ecnt1, blen0, blen1;
    wire  [3:0]        ecnt2, blen2;

    fifo_read #(.DATA_W(8), .SHOWAHEAD(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .rdfull(full[0]), .rdempty(empty[0]), .q(qd[0]),
        .rdreq(rdreq[0]), .dout(dout[0]), .dout_vld(vld[0]), .seq_err(serr[0]),
        .err_cnt(ecnt0), .burst_done(bdone[0]), .burst_len(blen0));
    fifo_read #(.DATA_W(8), .SHOWAHEAD(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .rdfull(full[1]), .rdempty(empty[1]), .q(qd[1]),
        .rdreq(rdreq[1]), .dout(dout[1]), .dout_vld(vld[1]), .seq_err(serr[1]),
        .err_cnt(ecnt1), .burst_done(bdone[1]), .burst_len(blen1));
    fifo_read #(.DATA_W(8), .SHOWAHEAD(1'b0), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .rdfull(full[2]), .rdempty(empty[2]), .q(qd[2]),
        .rdreq(rdreq[2]), .dout(dout[2]), .dout_vld(vld[2]), .seq_err(serr[2]),
        .err_cnt(ecnt2), .burst_done(bdone[2]), .burst_len(blen2));

    logic [7:0] fq    [N][$];
    logic [7:0] obs_d [N][$];
    logic       obs_e [N][$];
    int ndone[N], nreq[N], merr[N], first_req[N], first_vld[N], last_len[N], max_cnt[N];
    int cyc, tests, fails;

    function automatic logic [31:0] ecnt_of(input int i);
        case (i)
            0:       return 32'(ecnt0);
            1:       return 32'(ecnt1);
            default: return 32'(ecnt2);
        endcase
    endfunction

    function automatic logic [31:0] blen_of(input int i);
        case (i)
            0:       return 32'(blen0);
            1:       return 32'(blen1);
            default: return 32'(blen2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at negedge, then advance the FIFO models after the edge
    task automatic tick();
        logic [N-1:0] req_s;
        logic [7:0]   w;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("u%0d rdreq_while_empty", i), 32'(rdreq[i] & empty[i]), 32'd0);
            if (rdreq[i]) begin
                nreq[i]++;
                if (first_req[i] < 0) first_req[i] = cyc;
            end
            if (vld[i]) begin
                obs_d[i].push_back(dout[i]);
                obs_e[i].push_back(serr[i]);
                if (first_vld[i] < 0) first_vld[i] = cyc;
            end
            if (bdone[i]) begin
                ndone[i]++;
                last_len[i] = int'(blen_of(i));
            end
        end
        req_s = rdreq;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (req_s[i] && fq[i].size() > 0) begin
                w = fq[i].pop_front();
                if (i != 1) qd[i] = w;
                full[i] = 1'b0;
            end
            empty[i] = (fq[i].size() == 0);
            if (i == 1) qd[i] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
        end
    endtask

    task automatic load(input logic [7:0] words[$]);
        for (int i = 0; i < int'(N); i++) begin
            fq[i] = words;
            full[i] = 1'b1;
            empty[i] = 1'b0;
            obs_d[i].delete();
            obs_e[i].delete();
            nreq[i] = 0;
            first_req[i] = -1;
            first_vld[i] = -1;
        end
        qd[1] = (words.size() > 0) ? words[0] : 8'h00;
    endtask

    task automatic flush();
        for (int i = 0; i < int'(N); i++) begin
            fq[i].delete();
            full[i] = 1'b0;
            empty[i] = 1'b1;
            qd[i] = 8'h00;
        end
    endtask

    // Load a burst, drain it and compare everything against the sequence rules
    task automatic run_burst(input logic [7:0] words[$], input string name);
        int start[N];
        bit all_done;
        logic [7:0] exp_w;
        int nerr, n, exp_len;
        bit e;
        for (int i = 0; i < int'(N); i++) start[i] = ndone[i];
        load(words);
        all_done = 1'b0;
        for (int c = 0; c < 300 && !all_done; c++) begin
            tick();
            all_done = 1'b1;
            for (int i = 0; i < int'(N); i++) if (ndone[i] == start[i]) all_done = 1'b0;
        end
        tick();
        tick();
        full = '0;
        n = words.size();
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("%s u%0d burst_done count", name, i), 32'(ndone[i]), 32'(start[i] + 1));
            check($sformatf("%s u%0d words out", name, i), 32'(obs_d[i].size()), 32'(n));
            check($sformatf("%s u%0d rdreq cycles", name, i), 32'(nreq[i]), 32'(n));
            exp_w = 8'd0;
            nerr = 0;
            for (int k = 0; k < n; k++) begin
                e = (words[k] != exp_w);
                if (e) nerr++;
                exp_w = words[k] + 8'd1;
                if (k < obs_d[i].size()) begin
                    check($sformatf("%s u%0d dout[%0d]", name, i, k), 32'(obs_d[i][k]), 32'(words[k]));
                    check($sformatf("%s u%0d seq_err[%0d]", name, i, k), 32'(obs_e[i][k]), 32'(e));
                end
            end
            merr[i] = (merr[i] + nerr > max_cnt[i]) ? max_cnt[i] : merr[i] + nerr;
            exp_len = (n > max_cnt[i]) ? max_cnt[i] : n;
            check($sformatf("%s u%0d err_cnt", name, i), ecnt_of(i), 32'(merr[i]));
            check($sformatf("%s u%0d burst_len", name, i), 32'(last_len[i]), 32'(exp_len));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("%s u%0d rdreq", name, i), 32'(rdreq[i]), 32'd0);
            check($sformatf("%s u%0d dout", name, i), 32'(dout[i]), 32'd0);
            check($sformatf("%s u%0d dout_vld", name, i), 32'(vld[i]), 32'd0);
            check($sformatf("%s u%0d seq_err", name, i), 32'(serr[i]), 32'd0);
            check($sformatf("%s u%0d err_cnt", name, i), ecnt_of(i), 32'd0);
            check($sformatf("%s u%0d burst_done", name, i), 32'(bdone[i]), 32'd0);
            check($sformatf("%s u%0d burst_len", name, i), blen_of(i), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] w[$];
        logic [7:0] v;
        int n, d0;
        tests = 0;
        fails = 0;
        cyc = 0;
        max_cnt = '{65535, 65535, 15};
        for (int i = 0; i < int'(N); i++) begin
            ndone[i] = 0; nreq[i] = 0; merr[i] = 0; last_len[i] = 0;
            first_req[i] = -1; first_vld[i] = -1;
        end
        rst_n = 1'b0;
        flush();
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();

        // Clean 16-word burst plus read-to-data latency per FIFO flavour
        w = {};
        for (int k = 0; k < 16; k++) w.push_back(8'(k));
        run_burst(w, "seq16");
        check("latency u0", 32'(first_vld[0] - first_req[0]), 32'd2);
        check("latency u1", 32'(first_vld[1] - first_req[1]), 32'd1);
        check("latency u2", 32'(first_vld[2] - first_req[2]), 32'd2);

        w = {};
        w.push_back(8'd0); w.push_back(8'd1); w.push_back(8'd2); w.push_back(8'd4); w.push_back(8'd5);
        run_burst(w, "drop3");
        check("drop3 u0 one error", ecnt_of(0), 32'd1);

        w = {};
        for (int k = 0; k < 8; k++) w.push_back(8'(250 + k));
        run_burst(w, "wrap");
        check("wrap u0 one more error", ecnt_of(0), 32'd2);

        w = {};
        run_burst(w, "empty_burst");

        // Full and empty together must never start a read
        d0 = ndone[0];
        full = '1;
        empty = '1;
        for (int i = 0; i < int'(N); i++) begin
            nreq[i] = 0;
            obs_d[i].delete();
        end
        repeat (6) tick();
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("illegal u%0d rdreq", i), 32'(nreq[i]), 32'd0);
            check($sformatf("illegal u%0d dout_vld", i), 32'(obs_d[i].size()), 32'd0);
        end
        check("illegal u0 burst_done", 32'(ndone[0]), 32'(d0));
        full = '0;
        tick();

        // Asynchronous reset in the middle of a burst
        w = {};
        for (int k = 0; k < 16; k++) w.push_back(8'(k));
        load(w);
        repeat (7) tick();
        d0 = ndone[0];
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        flush();
        for (int i = 0; i < int'(N); i++) merr[i] = 0;
        repeat (3) tick();
        check("midreset no burst_done", 32'(ndone[0]), 32'(d0));
        rst_n = 1'b1;
        repeat (2) tick();
        run_burst(w, "after_reset");

        // Randomised bursts: mostly counting, occasional jumps and odd starts
        for (int b = 0; b < 12; b++) begin
            w = {};
            n = int'($urandom_range(1, 24));
            v = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
            for (int k = 0; k < n; k++) begin
                w.push_back(v);
                v = ($urandom_range(0, 5) == 0) ? 8'($urandom) : v + 8'd1;
            end
            run_burst(w, $sformatf("rand%0d", b));
        end

        // Narrow counters saturate at all-ones
        w = {};
        for (int k = 0; k < 20; k++) w.push_back(8'(k));
        run_burst(w, "len20");
        check("len20 u2 burst_len saturated", blen_of(2), 32'd15);
        w = {};
        for (int k = 0; k < 5; k++) w.push_back(8'd7);
        for (int b = 0; b < 4; b++) run_burst(w, $sformatf("bad%0d", b));
        check("u2 err_cnt saturated", ecnt_of(2), 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t, expected < 500000", $time);
        $fatal(1);
    end

endmodule
